keypad_conditioner: RTL and testbench
=====================================

// Module: keypad_conditioner
// PURPOSE
//  Front-end stage feeding combo_lock. Synchronises and debounces the raw keypad and
//  button lines, then issues one-cycle, one-hot press pulses on keypad/enter/clr/rst.
//  Rejects simultaneous multi-key presses, ignores keys added while one is held,
//  and flags stuck keys. All outputs connect directly to combo_lock inputs.
// PARAMETERS
//  DEBOUNCE_CYCLES  4     consecutive identical samples needed to accept a press (>=1)
//  RELEASE_CYCLES   4     consecutive all-zero samples needed to re-arm after a press (>=1)
//  STUCK_CYCLES     1000  held cycles after acceptance before stuck asserts (>DEBOUNCE_CYCLES)
//  CNT_W            16    width of press_count
// PORTS
//  clk          in   1      system clock, rising edge
//  hard_rst     in   1      asynchronous, active-high reset of the whole block
//  raw_keys     in   10     raw digit lines, bit n = digit n, asynchronous, may bounce
//  raw_enter    in   1      raw enter button
//  raw_clr      in   1      raw clear button
//  raw_rst      in   1      raw relock/reprogram button
//  keypad       out  10     one-cycle one-hot digit pulse to combo_lock
//  enter        out  1      one-cycle enter pulse
//  clr          out  1      one-cycle clear pulse
//  rst          out  1      one-cycle relock pulse
//  multi_err    out  1      one-cycle pulse: stable vector had >1 bit set, no press issued
//  stuck        out  1      level: accepted input held >= STUCK_CYCLES, clears on release
//  press_count  out  CNT_W  accepted presses (all four pulse types), wraps 2^CNT_W-1 -> 0
// BEHAVIOUR
//  - Reset: all outputs 0, press_count 0, sync flops 0, FSM IDLE, counters 0.
//  - Input vector v[12:0] = {raw_rst, raw_clr, raw_enter, raw_keys}; each bit passes a
//    2-flop synchroniser; FSM only sees synchronised vector s.
//  - FSM states: IDLE, DEBOUNCE, HELD.
//    IDLE: s==0 -> stay. s!=0 -> cand<=s, cnt<=1, go DEBOUNCE.
//    DEBOUNCE: s==0 -> IDLE (glitch dropped, no output). s!=cand -> cand<=s, cnt<=1.
//      s==cand -> cnt++; on the edge cnt would reach DEBOUNCE_CYCLES: if cand one-hot,
//      drive matching output bit high for that cycle and press_count++; else pulse
//      multi_err. Then go HELD, hold_cnt<=0, rel_cnt<=0.
//    HELD: no further pulses. s==0 -> rel_cnt++, at RELEASE_CYCLES go IDLE; s!=0 ->
//      rel_cnt<=0, hold_cnt++ (saturating); stuck<=1 when hold_cnt reaches STUCK_CYCLES.
//      Leaving HELD clears stuck.
//  - Latency: if edge k first samples raw input high and it stays stable, pulse is high
//    in the cycle after edge k+1+DEBOUNCE_CYCLES (edge k+5 for default). Width exactly 1.
//  - Delayed double press: second key added after acceptance lands in HELD -> ignored;
//    no pulse until all lines released RELEASE_CYCLES and pressed again.
//  - Simultaneous press (>1 bit stable through debounce): multi_err only, no press,
//    press_count unchanged; still requires full release.
//  - Second key added during DEBOUNCE: counts as new candidate, cnt restarts.
//  - Output pulses and multi_err mutually exclusive; at most one output bit high per cycle.
//  - hard_rst mid-debounce or mid-hold: immediate return to reset state, no pulse issued;
//    a key still held after reset release is debounced afresh as a new press.
// TESTING
//  1. Press raw_keys=10'h001 for 10 cycles, release -> keypad=10'h001 exactly 1 cycle at
//     edge k+5, press_count=1, multi_err=0.
//  2. raw_keys 10'h100 toggling every cycle for 3 cycles, then stable 6 cycles -> one
//     keypad=10'h100 pulse, 4 stable cycles after last bounce; press_count=1.
//  3. raw_keys=10'h100 stable 8 cycles, then 10'h180 for 5, then 0 -> single 10'h100 pulse,
//     no 10'h080 pulse, no multi_err.
//  4. raw_keys=10'h180 stable 8 cycles -> multi_err 1 cycle, keypad stays 0, count unchanged.
//  5. Sequence 8,0,8,6 then raw_enter, each 6 cycles on / 6 off -> pulses 10'h100,10'h001,
//     10'h100,10'h040, enter; press_count=5.
//  6. raw_keys=10'h002 held 1100 cycles (STUCK_CYCLES=1000) -> stuck=1 from hold cycle
//     1000, 0 after release; hard_rst mid-debounce of raw_clr -> no clr pulse, outputs 0.

Source files
------------

// File: rtl/keypad_conditioner.sv
// Keypad/button front-end for combo_lock: 2-flop sync, debounce, one-hot press pulses,
// multi-key rejection and stuck-key detection.
module keypad_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned RELEASE_CYCLES  = 4,
  parameter int unsigned STUCK_CYCLES    = 1000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk,
  input  logic             hard_rst,
  input  logic [9:0]       raw_keys,
  input  logic             raw_enter,
  input  logic             raw_clr,
  input  logic             raw_rst,
  output logic [9:0]       keypad,
  output logic             enter,
  output logic             clr,
  output logic             rst,
  output logic             multi_err,
  output logic             stuck,
  output logic [CNT_W-1:0] press_count
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RW = $clog2(RELEASE_CYCLES + 1);
  localparam int unsigned HW = $clog2(STUCK_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD} state_t;

  state_t        state;
  logic [12:0]   sync1, s;
  logic [12:0]   cand;
  logic [DW-1:0] cnt;
  logic [RW-1:0] rel_cnt;
  logic [HW-1:0] hold_cnt;
  logic          accept;
  logic          one_hot;

  always_ff @(posedge clk or posedge hard_rst) begin
    if (hard_rst) begin
      sync1 <= '0;
      s     <= '0;
    end else begin
      sync1 <= {raw_rst, raw_clr, raw_enter, raw_keys};
      s     <= sync1;
    end
  end

  // Acceptance always happens on a cycle where s equals the candidate, so s is the vector to issue.
  always_comb begin
    accept = 1'b0;
    if (state == IDLE && s != '0 && DEBOUNCE_CYCLES == 1)
      accept = 1'b1;
    else if (state == DEBOUNCE && s != '0 && s == cand &&
             (cnt + DW'(1)) == DW'(DEBOUNCE_CYCLES))
      accept = 1'b1;
    one_hot = (s != '0) && ((s & (s - 13'd1)) == '0);
  end

  always_ff @(posedge clk or posedge hard_rst) begin
    if (hard_rst) begin
      state       <= IDLE;
      cand        <= '0;
      cnt         <= '0;
      rel_cnt     <= '0;
      hold_cnt    <= '0;
      keypad      <= '0;
      enter       <= 1'b0;
      clr         <= 1'b0;
      rst         <= 1'b0;
      multi_err   <= 1'b0;
      stuck       <= 1'b0;
      press_count <= '0;
    end else begin
      {rst, clr, enter, keypad} <= '0;
      multi_err                 <= 1'b0;
      if (accept) begin
        if (one_hot) begin
          {rst, clr, enter, keypad} <= s;
          press_count               <= press_count + CNT_W'(1);
        end else begin
          multi_err <= 1'b1;
        end
        state    <= HELD;
        hold_cnt <= '0;
        rel_cnt  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (s != '0) begin
              cand  <= s;
              cnt   <= DW'(1);
              state <= DEBOUNCE;
            end
          end
          DEBOUNCE: begin
            if (s == '0) begin
              state <= IDLE;
            end else if (s != cand) begin
              cand <= s;
              cnt  <= DW'(1);
            end else begin
              cnt <= cnt + DW'(1);
            end
          end
          HELD: begin
            if (s == '0) begin
              if ((rel_cnt + RW'(1)) == RW'(RELEASE_CYCLES)) begin
                state   <= IDLE;
                stuck   <= 1'b0;
                rel_cnt <= '0;
              end else begin
                rel_cnt <= rel_cnt + RW'(1);
              end
            end else begin
              rel_cnt <= '0;
              if (hold_cnt != HW'(STUCK_CYCLES)) begin
                hold_cnt <= hold_cnt + HW'(1);
                if ((hold_cnt + HW'(1)) == HW'(STUCK_CYCLES))
                  stuck <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_conditioner.sv
// Scoreboard bench for keypad_conditioner: stimulus pushes expected pulses with their
// expected cycle; a monitor pops and compares whenever any pulse output is high.
module tb_keypad_conditioner;

  logic        clk = 1'b0;
  logic        hard_rst;
  logic [9:0]  raw_keys;
  logic        raw_enter, raw_clr, raw_rst;
  logic [9:0]  keypad;
  logic        enter, clr, rst, multi_err, stuck;
  logic [15:0] press_count;

  keypad_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .RELEASE_CYCLES (4),
    .STUCK_CYCLES   (1000),
    .CNT_W          (16)
  ) dut (
    .clk        (clk),
    .hard_rst   (hard_rst),
    .raw_keys   (raw_keys),
    .raw_enter  (raw_enter),
    .raw_clr    (raw_clr),
    .raw_rst    (raw_rst),
    .keypad     (keypad),
    .enter      (enter),
    .clr        (clr),
    .rst        (rst),
    .multi_err  (multi_err),
    .stuck      (stuck),
    .press_count(press_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] v;
    int unsigned cyc;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int unsigned exp_count = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: {multi_err, rst, clr, enter, keypad}
  always @(negedge clk) begin
    logic [13:0] act;
    exp_t        e;
    act = {multi_err, rst, clr, enter, keypad};
    if (act != '0) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse got=%h at cyc %0d, required none", act, cyc);
      end else begin
        e = q.pop_front();
        if (act !== e.v || cyc != e.cyc) begin
          errors++;
          $display("FAIL pulse got=%h@%0d required=%h@%0d", act, cyc, e.v, e.cyc);
        end
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic drive(input logic [12:0] v);
    {raw_rst, raw_clr, raw_enter, raw_keys} = v;
  endtask

  // Expect the pulse for input v (first sampled at the next edge) after DEBOUNCE+2 edges.
  task automatic expect_press(input logic [12:0] v, input logic is_multi);
    exp_t e;
    e.v   = is_multi ? {1'b1, 13'h0} : {1'b0, v};
    e.cyc = cyc + 6;
    q.push_back(e);
    if (!is_multi) exp_count++;
  endtask

  task automatic press(input logic [12:0] v, input int on_c, input int off_c,
                       input logic is_multi);
    drive(v);
    expect_press(v, is_multi);
    tick(on_c);
    drive('0);
    tick(off_c);
  endtask

  task automatic check_count(input string name);
    checks++;
    if (press_count != 16'(exp_count)) begin
      errors++;
      $display("FAIL %s press_count got=%0d required=%0d", name, press_count, exp_count);
    end
  endtask

  task automatic check_stuck(input string name, input logic want);
    checks++;
    if (stuck !== want) begin
      errors++;
      $display("FAIL %s stuck got=%b required=%b", name, stuck, want);
    end
  endtask

  initial begin
    hard_rst = 1'b1;
    drive('0);
    tick(3);
    checks++;
    if ({multi_err, rst, clr, enter, keypad, stuck} != '0 || press_count != '0) begin
      errors++;
      $display("FAIL reset_state outputs=%h count=%0d required all 0",
               {multi_err, rst, clr, enter, keypad, stuck}, press_count);
    end
    hard_rst = 1'b0;
    tick(2);

    // 1: single clean press
    press(13'h001, 10, 10, 1'b0);
    check_count("t1");

    // 2: bounce 1,0 then stable
    drive(13'h100); tick(1);
    drive(13'h000); tick(1);
    press(13'h100, 6, 10, 1'b0);
    check_count("t2");

    // 3: second key added while held is ignored
    drive(13'h100);
    expect_press(13'h100, 1'b0);
    tick(8);
    drive(13'h180); tick(5);
    drive('0); tick(10);
    check_count("t3");

    // 4: simultaneous press rejected
    press(13'h180, 8, 10, 1'b1);
    check_count("t4");

    // 5: digit sequence 8,0,8,6 then enter
    press(13'h100, 6, 6, 1'b0);
    press(13'h001, 6, 6, 1'b0);
    press(13'h100, 6, 6, 1'b0);
    press(13'h040, 6, 6, 1'b0);
    press(13'h400, 6, 6, 1'b0);
    tick(4);
    check_count("t5");

    // 6a: stuck key
    drive(13'h002);
    expect_press(13'h002, 1'b0);
    tick(1005);
    check_stuck("stuck_before", 1'b0);
    tick(1);
    check_stuck("stuck_at_1000", 1'b1);
    tick(94);
    drive('0);
    tick(10);
    check_stuck("stuck_released", 1'b0);
    check_count("t6");

    // 6b: hard reset mid-debounce of clr; key still held afterwards is a fresh press
    drive(13'h800);
    tick(4);
    hard_rst  = 1'b1;
    exp_count = 0;
    tick(2);
    checks++;
    if ({multi_err, rst, clr, enter, keypad, stuck} != '0 || press_count != '0) begin
      errors++;
      $display("FAIL mid_reset outputs=%h count=%0d required all 0",
               {multi_err, rst, clr, enter, keypad, stuck}, press_count);
    end
    hard_rst = 1'b0;
    expect_press(13'h800, 1'b0);
    tick(8);
    drive('0);
    tick(10);
    check_count("t6b");

    tick(20);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_pulses got=%0d outstanding required=0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
